// File: rtl/uart_rx_core.sv
// UART receive engine: synchronises the serial line, detects start bits, samples each
// bit at mid-period using a divisor-driven baud counter, and hands finished characters
// (with parity/framing flags) to the RX FIFO over a valid/ready handshake.
module uart_rx_core #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DIV_WIDTH   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic [1:0]           wls_i,
  input  logic                 pen_i,
  input  logic [1:0]           ps_i,
  input  logic                 stb_i,
  input  logic                 uart_rx_i,
  output logic [7:0]           rx_data_o,
  output logic                 rx_pe_o,
  output logic                 rx_fe_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 overrun_o,
  output logic                 busy_o
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop1,
    StStop2
  } state_e;

  // Line synchroniser and edge detection
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs_prev_q;
  logic                   rxs;
  logic                   fall;

  // Frame configuration captured at start detection
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [1:0]           wls_q, wls_d;
  logic                 pen_q, pen_d;
  logic [1:0]           ps_q, ps_d;
  logic                 stb_q, stb_d;
  logic [DIV_WIDTH-1:0] div_eff;

  // Frame engine state
  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] baud_q, baud_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [7:0]           shreg_q, shreg_d;
  logic                 pe_q, pe_d;
  logic                 fe_q, fe_d;
  logic                 sample;
  logic                 par_exp;
  logic                 complete;

  // Output holding registers
  logic [7:0] data_q, data_d;
  logic       ope_q, ope_d;
  logic       ofe_q, ofe_d;
  logic       valid_q, valid_d;
  logic       overrun_q, overrun_d;

  assign rxs     = sync_q[SYNC_STAGES-1];
  assign fall    = rxs_prev_q & ~rxs;
  assign sample  = (baud_q == '0);
  // Divisors below 2 would leave no room for a half-bit offset, so they run as 2.
  assign div_eff = (div_i < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div_i;

  // Synchroniser chain and registered copy of the synchronised line (idle high)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q     <= '1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], uart_rx_i};
      rxs_prev_q <= rxs;
    end
  end

  // Expected parity bit for the received data under the latched parity mode
  always_comb begin
    par_exp = 1'b0;
    case (ps_q)
      2'b00:   par_exp = ~^shreg_q;
      2'b01:   par_exp = ^shreg_q;
      2'b10:   par_exp = 1'b1;
      default: par_exp = 1'b0;
    endcase
  end

  // Frame FSM next-state: start detection, bit sampling, error accumulation
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    pe_d      = pe_q;
    fe_d      = fe_q;
    div_d     = div_q;
    wls_d     = wls_q;
    pen_d     = pen_q;
    ps_d      = ps_q;
    stb_d     = stb_q;
    complete  = 1'b0;

    if (baud_q != '0) begin
      baud_d = baud_q - DIV_WIDTH'(1);
    end

    case (state_q)
      StIdle: begin
        if (en_i && fall) begin
          state_d   = StStart;
          // First sample lands floor(D/2) cycles after the edge cycle.
          baud_d    = (div_eff >> 1) - DIV_WIDTH'(1);
          bit_cnt_d = 3'd0;
          shreg_d   = 8'h00;
          pe_d      = 1'b0;
          fe_d      = 1'b0;
          div_d     = div_eff;
          wls_d     = wls_i;
          pen_d     = pen_i;
          ps_d      = ps_i;
          stb_d     = stb_i;
        end
      end
      StStart: begin
        if (sample) begin
          baud_d  = div_q - DIV_WIDTH'(1);
          // A start bit that has gone high again by mid-bit is a glitch.
          state_d = rxs ? StIdle : StData;
        end
      end
      StData: begin
        if (sample) begin
          baud_d             = div_q - DIV_WIDTH'(1);
          shreg_d[bit_cnt_q] = rxs;
          // Last data bit index is word length - 1, i.e. 4 + wls.
          if (bit_cnt_q == {1'b1, wls_q}) begin
            state_d = pen_q ? StParity : StStop1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (sample) begin
          baud_d  = div_q - DIV_WIDTH'(1);
          if (rxs != par_exp) begin
            pe_d = 1'b1;
          end
          state_d = StStop1;
        end
      end
      StStop1: begin
        if (sample) begin
          baud_d = div_q - DIV_WIDTH'(1);
          if (!rxs) begin
            fe_d = 1'b1;
          end
          if (stb_q) begin
            state_d = StStop2;
          end else begin
            state_d  = StIdle;
            complete = 1'b1;
          end
        end
      end
      StStop2: begin
        if (sample) begin
          if (!rxs) begin
            fe_d = 1'b1;
          end
          state_d  = StIdle;
          complete = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Disabling the receiver abandons any frame in flight without producing output.
    if (!en_i) begin
      state_d  = StIdle;
      complete = 1'b0;
    end
  end

  // Output handshake: load on completion when the slot is free or being drained
  always_comb begin
    data_d    = data_q;
    ope_d     = ope_q;
    ofe_d     = ofe_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;

    if (valid_q && rx_ready_i) begin
      valid_d = 1'b0;
    end

    if (complete) begin
      if (!valid_q || rx_ready_i) begin
        data_d  = shreg_d;
        ope_d   = pe_d;
        ofe_d   = fe_d;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // Frame engine and configuration registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_cnt_q <= 3'd0;
      shreg_q   <= 8'h00;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
      div_q     <= DIV_WIDTH'(2);
      wls_q     <= 2'b00;
      pen_q     <= 1'b0;
      ps_q      <= 2'b00;
      stb_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      pe_q      <= pe_d;
      fe_q      <= fe_d;
      div_q     <= div_d;
      wls_q     <= wls_d;
      pen_q     <= pen_d;
      ps_q      <= ps_d;
      stb_q     <= stb_d;
    end
  end

  // Output holding registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q    <= 8'h00;
      ope_q     <= 1'b0;
      ofe_q     <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      ope_q     <= ope_d;
      ofe_q     <= ofe_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign rx_data_o  = data_q;
  assign rx_pe_o    = ope_q;
  assign rx_fe_o    = ofe_q;
  assign rx_valid_o = valid_q;
  assign overrun_o  = overrun_q;
  assign busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed scenarios plus randomised frames
// checked against a frame-level reference model (character, flags and latency).
module tb_uart_rx_core;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned DivWidth   = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                en;
  logic [DivWidth-1:0] div;
  logic [1:0]          wls;
  logic                pen;
  logic [1:0]          ps;
  logic                stb;
  logic                rx_line;
  logic [7:0]          rx_data;
  logic                rx_pe;
  logic                rx_fe;
  logic                rx_valid;
  logic                rx_ready;
  logic                overrun;
  logic                busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_rx_core #(
    .SYNC_STAGES(SyncStages),
    .DIV_WIDTH  (DivWidth)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_i      (en),
    .div_i     (div),
    .wls_i     (wls),
    .pen_i     (pen),
    .ps_i      (ps),
    .stb_i     (stb),
    .uart_rx_i (rx_line),
    .rx_data_o (rx_data),
    .rx_pe_o   (rx_pe),
    .rx_fe_o   (rx_fe),
    .rx_valid_o(rx_valid),
    .rx_ready_i(rx_ready),
    .overrun_o (overrun),
    .busy_o    (busy)
  );

  // Cycle counter and output monitor
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [9:0]  got_q[$];
  logic        valid_prev = 1'b0;
  int unsigned rise_cyc   = 0;
  logic        rise_busy  = 1'b0;
  int unsigned ov_cnt     = 0;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) got_q.push_back({rx_fe, rx_pe, rx_data});
    if (rx_valid && !valid_prev) begin
      rise_cyc  <= cyc;
      rise_busy <= busy;
    end
    if (overrun) ov_cnt <= ov_cnt + 1;
    valid_prev <= rx_valid;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1);
  end

  int unsigned start_cyc;
  int unsigned exp_latency;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    while (got_q.size() != 0) void'(got_q.pop_front());
  endtask

  task automatic get_char(output logic [9:0] c, output bit ok);
    ok = 1'b0;
    c  = '0;
    for (int i = 0; i < 400; i++) begin
      if (got_q.size() != 0) break;
      tick(1);
    end
    if (got_q.size() != 0) begin
      c  = got_q.pop_front();
      ok = 1'b1;
    end
  endtask

  // Reference model: drive one frame and compute the expected latency from the
  // edge to rx_valid_o (synchroniser + half bit + whole bits + completion cycle).
  task automatic send_frame(input logic [7:0] data, input logic [1:0] cw, input logic cpen,
                            input logic [1:0] cps, input logic cstb, input logic [15:0] cdiv,
                            input logic flip, input logic s1, input logic s2,
                            input logic scramble);
    int   n;
    int   d;
    int   ones;
    logic par;
    n    = int'(cw) + 5;
    d    = (cdiv < 16'd2) ? 2 : int'(cdiv);
    wls  = cw;
    pen  = cpen;
    ps   = cps;
    stb  = cstb;
    div  = cdiv;
    ones = 0;
    for (int i = 0; i < n; i++) ones += int'(data[i]);
    case (cps)
      2'b00:   par = (ones % 2 == 0);
      2'b01:   par = (ones % 2 == 1);
      2'b10:   par = 1'b1;
      default: par = 1'b0;
    endcase
    exp_latency = unsigned'(int'(SyncStages) + d / 2 +
                            (n + int'(cpen) + 1 + int'(cstb)) * d + 1);
    start_cyc = cyc;
    rx_line   = 1'b0;
    tick(d);
    for (int i = 0; i < n; i++) begin
      rx_line = data[i];
      tick(d);
      if (i == 0 && scramble) begin
        wls = 2'($urandom);
        pen = 1'($urandom);
        ps  = 2'($urandom);
        stb = 1'($urandom);
        div = 16'($urandom_range(0, 40));
      end
    end
    if (cpen) begin
      rx_line = par ^ flip;
      tick(d);
    end
    rx_line = s1;
    tick(d);
    if (cstb) begin
      rx_line = s2;
      tick(d);
    end
    rx_line = 1'b1;
    tick(d + 6);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; rx_line = 1'b1; rx_ready = 1'b1;
    div = 16'd16; wls = 2'b11; pen = 1'b0; ps = 2'b00; stb = 1'b0;
    tick(4);
    @(negedge clk);
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
    n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", rx_data); end
    n_tests++; if (rx_pe !== 1'b0) begin n_fail++; $display("FAIL reset_pe got=%b exp=0", rx_pe); end
    n_tests++; if (rx_fe !== 1'b0) begin n_fail++; $display("FAIL reset_fe got=%b exp=0", rx_fe); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    tick(4);
  endtask

  task automatic test_8n1_timing();
    logic [9:0] c; bit ok;
    rx_ready = 1'b1; drain();
    send_frame(8'hA5, 2'b11, 1'b0, 2'b00, 1'b0, 16'd16, 1'b0, 1'b1, 1'b1, 1'b0);
    get_char(c, ok);
    n_tests++; if (!ok || c !== {2'b00, 8'hA5}) begin n_fail++; $display("FAIL 8n1_char got=%h ok=%0d exp=%h", c, ok, {2'b00, 8'hA5}); end
    n_tests++; if (rise_cyc - start_cyc !== SyncStages + 153) begin n_fail++; $display("FAIL 8n1_latency got=%0d exp=%0d", rise_cyc - start_cyc, SyncStages + 153); end
  endtask

  task automatic test_parity_7e1();
    logic [9:0] c; bit ok;
    drain();
    send_frame(8'h35, 2'b10, 1'b1, 2'b01, 1'b0, 16'd4, 1'b0, 1'b1, 1'b1, 1'b0);
    get_char(c, ok);
    n_tests++; if (!ok || c !== {2'b00, 8'h35}) begin n_fail++; $display("FAIL 7e1_good got=%h ok=%0d exp=%h", c, ok, {2'b00, 8'h35}); end
    send_frame(8'h35, 2'b10, 1'b1, 2'b01, 1'b0, 16'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    get_char(c, ok);
    n_tests++; if (!ok || c !== {2'b01, 8'h35}) begin n_fail++; $display("FAIL 7e1_bad_parity got=%h ok=%0d exp=%h", c, ok, {2'b01, 8'h35}); end
  endtask

  task automatic test_5o2_framing();
    logic [9:0] c; bit ok;
    drain();
    send_frame(8'h1F, 2'b00, 1'b1, 2'b00, 1'b1, 16'd10, 1'b0, 1'b1, 1'b0, 1'b0);
    get_char(c, ok);
    n_tests++; if (!ok || c !== {2'b10, 8'h1F}) begin n_fail++; $display("FAIL 5o2_fe got=%h ok=%0d exp=%h", c, ok, {2'b10, 8'h1F}); end
    n_tests++; if (rise_busy !== 1'b0) begin n_fail++; $display("FAIL 5o2_busy_after got=%b exp=0", rise_busy); end
  endtask

  task automatic test_glitch();
    drain();
    div = 16'd16; wls = 2'b11; pen = 1'b0; stb = 1'b0;
    rx_line = 1'b0;
    tick(3);
    rx_line = 1'b1;
    tick(7);
    @(negedge clk);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_t0p8 got=%b exp=1", busy); end
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle_t0p9 got=%b exp=0", busy); end
    tick(60);
    n_tests++; if (got_q.size() != 0 || rx_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_no_char got=%0d exp=0", got_q.size()); end
  endtask

  task automatic test_overrun();
    logic [9:0] c; bit ok;
    int unsigned base;
    rx_ready = 1'b0; drain();
    base = ov_cnt;
    send_frame(8'h11, 2'b11, 1'b0, 2'b00, 1'b0, 16'd8, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    n_tests++; if ({rx_valid, rx_data} !== {1'b1, 8'h11}) begin n_fail++; $display("FAIL ovr_first got=%b/%h exp=1/11", rx_valid, rx_data); end
    tick(1);
    send_frame(8'h22, 2'b11, 1'b0, 2'b00, 1'b0, 16'd8, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    n_tests++; if (ov_cnt - base !== 1) begin n_fail++; $display("FAIL ovr_pulses got=%0d exp=1", ov_cnt - base); end
    n_tests++; if ({rx_valid, rx_data} !== {1'b1, 8'h11}) begin n_fail++; $display("FAIL ovr_held got=%b/%h exp=1/11", rx_valid, rx_data); end
    tick(1);
    rx_ready = 1'b1;
    get_char(c, ok);
    n_tests++; if (!ok || c !== {2'b00, 8'h11}) begin n_fail++; $display("FAIL ovr_drain got=%h ok=%0d exp=%h", c, ok, {2'b00, 8'h11}); end
    @(negedge clk);
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_valid_drop got=%b exp=0", rx_valid); end
    tick(2);
  endtask

  task automatic test_div_clamp();
    logic [9:0] c; bit ok;
    drain();
    send_frame(8'h5A, 2'b11, 1'b0, 2'b00, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    get_char(c, ok);
    n_tests++; if (!ok || c !== {2'b00, 8'h5A}) begin n_fail++; $display("FAIL div0_char got=%h ok=%0d exp=%h", c, ok, {2'b00, 8'h5A}); end
    n_tests++; if (rise_cyc - start_cyc !== SyncStages + 20) begin n_fail++; $display("FAIL div0_latency got=%0d exp=%0d", rise_cyc - start_cyc, SyncStages + 20); end
    send_frame(8'hC3, 2'b11, 1'b0, 2'b00, 1'b0, 16'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    get_char(c, ok);
    n_tests++; if (!ok || c !== {2'b00, 8'hC3}) begin n_fail++; $display("FAIL div1_char got=%h ok=%0d exp=%h", c, ok, {2'b00, 8'hC3}); end
    n_tests++; if (rise_cyc - start_cyc !== SyncStages + 20) begin n_fail++; $display("FAIL div1_latency got=%0d exp=%0d", rise_cyc - start_cyc, SyncStages + 20); end
  endtask

  task automatic test_reset_midframe();
    logic [9:0] c; bit ok;
    logic [7:0] d;
    rx_ready = 1'b0; drain();
    send_frame(8'h77, 2'b11, 1'b0, 2'b00, 1'b0, 16'd8, 1'b0, 1'b1, 1'b1, 1'b0);
    d = 8'hC9;
    rx_line = 1'b0;
    tick(8);
    for (int i = 0; i < 3; i++) begin
      rx_line = d[i];
      tick(8);
    end
    rx_line = d[3];
    tick(4);
    rst = 1'b1;
    rx_line = 1'b1;
    tick(1);
    @(negedge clk);
    n_tests++; if ({rx_valid, rx_data, rx_pe, rx_fe, overrun, busy} !== 13'h0) begin n_fail++; $display("FAIL rstmid_outputs got=%h exp=0", {rx_valid, rx_data, rx_pe, rx_fe, overrun, busy}); end
    rst = 1'b0;
    rx_ready = 1'b1;
    tick(20);
    n_tests++; if (got_q.size() != 0) begin n_fail++; $display("FAIL rstmid_lost got=%0d exp=0", got_q.size()); end
    send_frame(8'h3C, 2'b11, 1'b0, 2'b00, 1'b0, 16'd8, 1'b0, 1'b1, 1'b1, 1'b0);
    get_char(c, ok);
    n_tests++; if (!ok || c !== {2'b00, 8'h3C}) begin n_fail++; $display("FAIL rstmid_next got=%h ok=%0d exp=%h", c, ok, {2'b00, 8'h3C}); end
  endtask

  task automatic test_enable();
    logic [9:0] c; bit ok;
    rx_ready = 1'b1; drain();
    div = 16'd8; wls = 2'b11; pen = 1'b0; stb = 1'b0;
    rx_line = 1'b0;
    tick(8);
    rx_line = 1'b0;
    tick(16);
    en = 1'b0;
    tick(1);
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL en_abort_busy got=%b exp=0", busy); end
    rx_line = 1'b1;
    tick(100);
    en = 1'b1;
    tick(10);
    n_tests++; if (got_q.size() != 0) begin n_fail++; $display("FAIL en_no_char got=%0d exp=0", got_q.size()); end
    send_frame(8'h96, 2'b11, 1'b0, 2'b00, 1'b0, 16'd8, 1'b0, 1'b1, 1'b1, 1'b0);
    get_char(c, ok);
    n_tests++; if (!ok || c !== {2'b00, 8'h96}) begin n_fail++; $display("FAIL en_recover got=%h ok=%0d exp=%h", c, ok, {2'b00, 8'h96}); end
  endtask

  task automatic test_break();
    logic [9:0] c; bit ok;
    rx_ready = 1'b1; drain();
    div = 16'd4; wls = 2'b11; pen = 1'b0; stb = 1'b0;
    rx_line = 1'b0;
    tick(4 * 14);
    rx_line = 1'b1;
    tick(30);
    n_tests++; if (got_q.size() != 1) begin n_fail++; $display("FAIL break_count got=%0d exp=1", got_q.size()); end
    get_char(c, ok);
    n_tests++; if (!ok || c !== {2'b10, 8'h00}) begin n_fail++; $display("FAIL break_char got=%h ok=%0d exp=%h", c, ok, {2'b10, 8'h00}); end
  endtask

  task automatic test_random();
    logic [9:0] c; bit ok;
    logic [7:0] data, mask;
    logic [1:0] cw, cps;
    logic       cpen, cstb, flip, s1, s2;
    logic [15:0] cdiv;
    logic [9:0] exp;
    rx_ready = 1'b1; drain();
    for (int k = 0; k < 20; k++) begin
      data = 8'($urandom);
      cw   = 2'($urandom);
      cps  = 2'($urandom);
      cpen = 1'($urandom);
      cstb = 1'($urandom);
      flip = 1'($urandom);
      s1   = ($urandom_range(0, 3) != 0);
      s2   = ($urandom_range(0, 3) != 0);
      cdiv = 16'($urandom_range(0, 12));
      mask = 8'((1 << (int'(cw) + 5)) - 1);
      exp  = {(!s1 || (cstb && !s2)), (cpen && flip), data & mask};
      send_frame(data, cw, cpen, cps, cstb, cdiv, flip, s1, s2, 1'b1);
      get_char(c, ok);
      n_tests++; if (!ok || c !== exp) begin n_fail++; $display("FAIL rand%0d_char got=%h ok=%0d exp=%h", k, c, ok, exp); end
      n_tests++; if (rise_cyc - start_cyc !== exp_latency) begin n_fail++; $display("FAIL rand%0d_latency got=%0d exp=%0d", k, rise_cyc - start_cyc, exp_latency); end
    end
  endtask

  initial begin
    test_reset();
    test_8n1_timing();
    test_parity_7e1();
    test_5o2_framing();
    test_glitch();
    test_overrun();
    test_div_clamp();
    test_reset_midframe();
    test_enable();
    test_break();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Receive-side serial engine of the UART.
- Deserialises uart_rx_i into 5–8-bit characters using the LCR and DIV register fields (word length, parity, stop bits, divisor).
- Presents each character with error flags on a valid/ready handshake to the RX FIFO.
- Sits between the uart_if pin and the RX FIFO; the LSR PE, DR and RXIP logic consumes its outputs.

Parameters:
- SYNC_STAGES, 2, number of flops in the uart_rx_i synchroniser (≥2).
- DIV_WIDTH, 16, width of the divisor input; matches the DIV register field.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  reset, synchronous, active-high.
- en_i  in  1  receiver enable; low forces IDLE.
- div_i  in  DIV_WIDTH  clk_i cycles per bit; values below 2 are treated as 2.
- wls_i  in  2  word length: 00=5, 01=6, 10=7, 11=8 data bits.
- pen_i  in  1  parity enable.
- ps_i  in  2  parity select: 00 odd, 01 even, 10 mark (1), 11 space (0).
- stb_i  in  1  0 = one stop bit, 1 = two stop bits.
- uart_rx_i  in  1  asynchronous serial input; idles high.
- rx_data_o  out  8  received character, LSB-aligned, unused MSBs 0.
- rx_pe_o  out  1  parity error for rx_data_o.
- rx_fe_o  out  1  framing error (a stop bit sampled 0) for rx_data_o.
- rx_valid_o  out  1  character available.
- rx_ready_i  in  1  consumer accepts the character.
- overrun_o  out  1  one-cycle pulse: a completed character was dropped.
- busy_o  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset:
  - All outputs are 0.
  - The synchroniser flops reset to 1.
  - FSM goes to IDLE; bit counter and baud counter go to 0.
- Synchroniser: uart_rx_i passes through SYNC_STAGES flops; rxs is the last stage. Edge detection uses rxs and its registered copy.
- Configuration latch: div_i (clamped), wls_i, pen_i, ps_i and stb_i are latched at start detection. Changes mid-frame do not affect the current frame.
- Sample times: let t0 be the first cycle rxs==0 after it was 1, in IDLE with en_i=1, and let D be the latched divisor.
  - Start-bit sample at t0+floor(D/2).
  - Each later bit is sampled exactly D cycles after the previous sample.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE -> START on falling edge with en_i=1.
  - START: sample 0 -> DATA; sample 1 -> IDLE (glitch rejected, no output).
  - DATA: shift LSB-first for N=5..8 bits, then go to PARITY if pen, else STOP1.
  - PARITY: compare the sample to the expected bit.
    - Odd: expected = ~^data.
    - Even: expected = ^data.
    - Mark: expected = 1.
    - Space: expected = 0.
    - A mismatch sets the pending pe flag.
  - STOP1: sample 0 sets the pending fe flag. Go to STOP2 if stb, else complete.
  - STOP2: sample 0 sets fe. Complete.
- Completion, one cycle after the final stop sample:
  - If rx_valid_o==0, or rx_valid_o && rx_ready_i in that same cycle: load rx_data_o, rx_pe_o and rx_fe_o, and set rx_valid_o.
  - Otherwise the new character is discarded, overrun_o pulses for one cycle, and the held output is unchanged.
  - FSM returns to IDLE. A new start edge may be detected the cycle after completion.
- Handshake: rx_valid_o stays high and the data/flags stay stable until rx_valid_o && rx_ready_i. On that handshake, rx_valid_o clears next cycle unless completion reloads it in the same cycle.
- Break (line held 0): completes with data 0 and fe=1. No new start is detected until rxs has returned to 1.
- en_i deasserted mid-frame: FSM returns to IDLE next cycle with no output. rx_valid_o and held data are unaffected.
- rst_i mid-frame: immediate return to reset state; a pending character is lost.
- Counters: the baud counter is DIV_WIDTH bits and counts down to 0 without wrapping. The bit counter is 3 bits.

Test Plan:
- 8N1, div=16, serialise 0xA5, ready=1 -> start sample at t0+8; rx_valid_o rises at t0+153; data=0xA5, pe=0, fe=0.
- 7E1, div=4, serialise 0x35 with correct parity, then 0x35 with flipped parity bit -> first character pe=0; second pe=1, data=0x35.
- 5O2, div=10, serialise 0x1F with second stop bit driven 0 -> data=0x1F, fe=1, pe=0; busy_o low the cycle after completion.
- Low glitch of 3 cycles at div=16 -> no rx_valid_o, FSM back in IDLE by t0+9.
- ready=0, send 0x11 then 0x22 -> rx_data_o holds 0x11; overrun_o pulses once at the second completion; after ready, rx_valid_o drops.
- div=0 with 0x5A -> behaves exactly as div=2. Assert rst_i at the 4th data bit -> all outputs 0 next cycle; a following 0x3C frame is received correctly.
